// File: rtl/set_scan_pkg.sv
// set_scan_pkg: mode codes, FSM state encoding and popcount helper shared by the
// set scan controller and its predicate.
package set_scan_pkg;

   localparam int MAX_SETS = 8;

   // Codes 5..7 are reserved and never match, so modes stay plain 3-bit codes.
   localparam logic [2:0] MODE_UNION     = 3'd0;
   localparam logic [2:0] MODE_INTER     = 3'd1;
   localparam logic [2:0] MODE_PARITY    = 3'd2;
   localparam logic [2:0] MODE_EXACT_K   = 3'd3;
   localparam logic [2:0] MODE_ATLEAST_K = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_e;

   function automatic logic [3:0] popcount(input logic [MAX_SETS-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < MAX_SETS; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/set_scan_ctrl_if.sv
// set_scan_ctrl_if: host command and map-read bundle of the set scan controller.
// Defining SET_SCAN_POP_EN adds the per-map population count bus set_pop.
interface set_scan_ctrl_if #(
   parameter int NUM_SETS = 4,
   parameter int DEPTH    = 64
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int K_W    = $clog2(NUM_SETS + 1);

   logic                start;
   logic [2:0]          mode;
   logic [NUM_SETS-1:0] sel_mask;
   logic [K_W-1:0]      k;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [NUM_SETS-1:0] rd_bit;
   logic                busy;
   logic                valid;
   logic [CNT_W-1:0]    result;
`ifdef SET_SCAN_POP_EN
   logic [NUM_SETS*CNT_W-1:0] set_pop;

   modport master (
      output start, mode, sel_mask, k, rd_bit,
      input  rd_en, rd_addr, busy, valid, result, set_pop
   );

   modport slave (
      input  start, mode, sel_mask, k, rd_bit,
      output rd_en, rd_addr, busy, valid, result, set_pop
   );
`else
   modport master (
      output start, mode, sel_mask, k, rd_bit,
      input  rd_en, rd_addr, busy, valid, result
   );

   modport slave (
      input  start, mode, sel_mask, k, rd_bit,
      output rd_en, rd_addr, busy, valid, result
   );
`endif

endinterface

// File: rtl/set_scan_pred.sv
// set_scan_pred: combinational per-address set predicate on the masked map bits.
// Kept standalone so wider word-parallel scanners can instantiate one per lane.
module set_scan_pred
   import set_scan_pkg::*;
#(
   parameter int NUM_SETS = 4,
   parameter int K_W      = $clog2(NUM_SETS + 1)
) (
   input  logic [NUM_SETS-1:0] m,
   input  logic [NUM_SETS-1:0] mask,
   input  logic [K_W-1:0]      k,
   input  logic [2:0]          mode,
   output logic                match
);

   logic [MAX_SETS-1:0] m_ext;
   logic [MAX_SETS-1:0] mask_ext;
   logic [3:0]          p;
   logic [3:0]          n;
   logic [3:0]          k_ext;

   always_comb begin
      m_ext                   = '0;
      mask_ext                = '0;
      m_ext[NUM_SETS-1:0]     = m;
      mask_ext[NUM_SETS-1:0]  = mask;
      p                       = popcount(m_ext);
      n                       = popcount(mask_ext);
      k_ext                   = 4'(k);
      match                   = 1'b0;
      case (mode)
         MODE_UNION:     match = (p != 4'd0);
         MODE_INTER:     match = (n != 4'd0) && (p == n);
         MODE_PARITY:    match = p[0];
         MODE_EXACT_K:   match = (p == k_ext);
         MODE_ATLEAST_K: match = (p >= k_ext);
         default:        match = 1'b0;
      endcase
   end

endmodule

// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: sweeps a shared read address over NUM_SETS bit maps and counts the
// addresses satisfying the selected set predicate. SET_SCAN_POP_EN adds per-map counts.
module set_scan_ctrl
   import set_scan_pkg::*;
#(
   parameter int NUM_SETS = 4,
   parameter int DEPTH    = 64
) (
   input  logic           clk,
   input  logic           rst,
   set_scan_ctrl_if.slave bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int K_W    = $clog2(NUM_SETS + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   scan_state_e         state_q, state_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                bit_vld_q, bit_vld_d;
   logic [CNT_W-1:0]    result_q, result_d;
   logic [2:0]          mode_q, mode_d;
   logic [NUM_SETS-1:0] mask_q, mask_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [NUM_SETS-1:0] m;
   logic                match;

   assign m = bus.rd_bit & mask_q;

   set_scan_pred #(
      .NUM_SETS (NUM_SETS),
      .K_W      (K_W)
   ) u_pred (
      .m     (m),
      .mask  (mask_q),
      .k     (k_q),
      .mode  (mode_q),
      .match (match)
   );

   // bit_vld trails rd_en by one cycle, matching the map read latency.
   always_comb begin
      state_d   = state_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      bit_vld_d = rd_en_q;
      result_d  = result_q;
      mode_d    = mode_q;
      mask_d    = mask_q;
      k_d       = k_q;

      if (bit_vld_q && match) begin
         result_d = result_q + CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               mode_d    = bus.mode;
               mask_d    = bus.sel_mask;
               k_d       = bus.k;
               result_d  = '0;
               rd_addr_d = '0;
               rd_en_d   = 1'b1;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (rd_addr_q == LAST_ADDR) begin
               rd_en_d   = 1'b0;
               rd_addr_d = '0;
               state_d   = ST_DRAIN;
            end else begin
               rd_addr_d = rd_addr_q + ADDR_ONE;
            end
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         bit_vld_q <= 1'b0;
         result_q  <= '0;
         mode_q    <= '0;
         mask_q    <= '0;
         k_q       <= '0;
      end else begin
         state_q   <= state_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         bit_vld_q <= bit_vld_d;
         result_q  <= result_d;
         mode_q    <= mode_d;
         mask_q    <= mask_d;
         k_q       <= k_d;
      end
   end

   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.valid   = (state_q == ST_DONE);
   assign bus.result  = result_q;

`ifdef SET_SCAN_POP_EN
   logic [CNT_W-1:0] pop_q [NUM_SETS];
   logic [CNT_W-1:0] pop_d [NUM_SETS];

   // Population counts see every returned bit regardless of sel_mask.
   always_comb begin
      for (int i = 0; i < NUM_SETS; i++) begin
         pop_d[i] = pop_q[i];
         if (bit_vld_q && bus.rd_bit[i]) begin
            pop_d[i] = pop_q[i] + CNT_ONE;
         end
         if ((state_q == ST_IDLE) && bus.start) begin
            pop_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SETS; i++) begin
            pop_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SETS; i++) begin
            pop_q[i] <= pop_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_SETS; g++) begin : g_pop_out
      assign bus.set_pop[g*CNT_W +: CNT_W] = pop_q[g];
   end
`endif

endmodule

// File: tb/tb_set_scan_ctrl.sv
// tb_set_scan_ctrl: directed bench for set_scan_ctrl with a one-cycle-latency map model.
// With SET_SCAN_POP_EN defined it also checks the per-map population counts.
module tb_set_scan_ctrl;
   import set_scan_pkg::*;

   localparam int NUM_SETS = 4;
   localparam int DEPTH    = 64;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic [NUM_SETS-1:0] mem [DEPTH];

   set_scan_ctrl_if #(.NUM_SETS(NUM_SETS), .DEPTH(DEPTH)) bus ();

   set_scan_ctrl #(.NUM_SETS(NUM_SETS), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Map model: data one cycle after rd_en, garbage when no read was issued.
   always @(posedge clk or posedge rst) begin
      if (rst) bus.rd_bit <= '0;
      else if (bus.rd_en) bus.rd_bit <= mem[bus.rd_addr];
      else bus.rd_bit <= 4'hF;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic load_pattern1();
      for (int a = 0; a < DEPTH; a++) begin
         mem[a] = {1'b1, 1'b0, (a >= 5 && a <= 19), (a <= 9)};
      end
   endtask

   task automatic load_pattern2();
      for (int a = 0; a < DEPTH; a++) begin
         mem[a] = (a % 2 == 0) ? 4'b1111 : 4'b0001;
      end
   endtask

   // Issues one command and watches it; index i counts edges after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [3:0] msk, input logic [2:0] kk,
                                input int mid_cyc, input logic [2:0] alt_op, input logic [3:0] alt_msk,
                                input bit hold_at_done,
                                output int valid_at, output int valid_cnt, output int busy_cnt,
                                output int res, output bit timed_out);
      valid_at = -1; valid_cnt = 0; busy_cnt = 0; res = -1; timed_out = 1'b1;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = op; bus.sel_mask = msk; bus.k = kk;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (i == mid_cyc) begin
            bus.start = 1'b1; bus.mode = alt_op; bus.sel_mask = alt_msk;
         end else if (i == mid_cyc + 1) begin
            bus.start = 1'b0;
         end
         if (bus.busy) busy_cnt++;
         if (bus.valid) begin
            valid_cnt++; valid_at = i; res = int'(bus.result);
            if (hold_at_done) begin
               bus.start = 1'b1; bus.mode = alt_op; bus.sel_mask = alt_msk;
            end
         end
         if (!bus.busy) begin timed_out = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = '0; bus.sel_mask = '0; bus.k = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid); end
      n_cmp++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_en: got %b expected 0", bus.rd_en); end
      n_cmp++; if (bus.rd_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_rd_addr: got %0d expected 0", bus.rd_addr); end
      n_cmp++; if (bus.result !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_result: got %0d expected 0", bus.result); end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_union_inter_parity();
      int va, vc, bc, r; bit to;
      load_pattern1();
      applyStimulus(MODE_UNION, 4'b0011, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 20) begin n_fail++; $display("[TB] FAIL union_result: got %0d expected 20", r); end
      n_cmp++; if (va !== 65) begin n_fail++; $display("[TB] FAIL union_valid_at: got %0d expected 65", va); end
      n_cmp++; if (vc !== 1) begin n_fail++; $display("[TB] FAIL union_valid_pulses: got %0d expected 1", vc); end
      n_cmp++; if (bc !== 66) begin n_fail++; $display("[TB] FAIL union_busy_cycles: got %0d expected 66", bc); end
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL union_timeout: got %b expected 0", to); end
      applyStimulus(MODE_INTER, 4'b0011, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 5) begin n_fail++; $display("[TB] FAIL inter_result: got %0d expected 5", r); end
      applyStimulus(MODE_PARITY, 4'b0011, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 15) begin n_fail++; $display("[TB] FAIL parity_result: got %0d expected 15", r); end
      applyStimulus(MODE_ATLEAST_K, 4'b1111, 3'd3, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 5) begin n_fail++; $display("[TB] FAIL atleast3_result: got %0d expected 5", r); end
      applyStimulus(MODE_EXACT_K, 4'b1111, 3'd2, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 15) begin n_fail++; $display("[TB] FAIL exact2_p1_result: got %0d expected 15", r); end
   endtask

   task automatic test_thresholds();
      int va, vc, bc, r; bit to;
      load_pattern2();
      applyStimulus(MODE_EXACT_K, 4'b1111, 3'd2, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 0) begin n_fail++; $display("[TB] FAIL exact2_result: got %0d expected 0", r); end
      applyStimulus(MODE_ATLEAST_K, 4'b1111, 3'd1, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 64) begin n_fail++; $display("[TB] FAIL atleast1_result: got %0d expected 64", r); end
      applyStimulus(MODE_EXACT_K, 4'b1111, 3'd1, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 32) begin n_fail++; $display("[TB] FAIL exact1_result: got %0d expected 32", r); end
      applyStimulus(MODE_EXACT_K, 4'b1111, 3'd4, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 32) begin n_fail++; $display("[TB] FAIL exact4_result: got %0d expected 32", r); end
      applyStimulus(MODE_INTER, 4'b0110, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 32) begin n_fail++; $display("[TB] FAIL inter_p2_result: got %0d expected 32", r); end
   endtask

   task automatic test_mask_zero_reserved();
      int va, vc, bc, r; bit to;
      load_pattern2();
      applyStimulus(MODE_UNION, 4'b0000, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 0) begin n_fail++; $display("[TB] FAIL mask0_union: got %0d expected 0", r); end
      applyStimulus(MODE_INTER, 4'b0000, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 0) begin n_fail++; $display("[TB] FAIL mask0_inter: got %0d expected 0", r); end
      applyStimulus(MODE_PARITY, 4'b0000, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 0) begin n_fail++; $display("[TB] FAIL mask0_parity: got %0d expected 0", r); end
      applyStimulus(MODE_EXACT_K, 4'b0000, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 64) begin n_fail++; $display("[TB] FAIL mask0_exact0: got %0d expected 64", r); end
      applyStimulus(MODE_ATLEAST_K, 4'b0011, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 64) begin n_fail++; $display("[TB] FAIL atleast0_result: got %0d expected 64", r); end
      applyStimulus(3'd5, 4'b1111, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 0) begin n_fail++; $display("[TB] FAIL reserved_result: got %0d expected 0", r); end
      n_cmp++; if (va !== 65) begin n_fail++; $display("[TB] FAIL reserved_valid_at: got %0d expected 65", va); end
      n_cmp++; if (bc !== 66) begin n_fail++; $display("[TB] FAIL reserved_busy_cycles: got %0d expected 66", bc); end
   endtask

   task automatic test_back_to_back();
      int va, vc, bc, r; bit to;
      load_pattern1();
      applyStimulus(MODE_UNION, 4'b0011, 3'd0, 10, MODE_PARITY, 4'b0011, 1'b1, va, vc, bc, r, to);
      n_cmp++; if (r !== 20) begin n_fail++; $display("[TB] FAIL ignored_start_result: got %0d expected 20", r); end
      n_cmp++; if (bc !== 66) begin n_fail++; $display("[TB] FAIL done_start_busy_cycles: got %0d expected 66", bc); end
      n_cmp++; if (vc !== 1) begin n_fail++; $display("[TB] FAIL ignored_start_pulses: got %0d expected 1", vc); end
      applyStimulus(MODE_PARITY, 4'b0011, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 15) begin n_fail++; $display("[TB] FAIL after_done_result: got %0d expected 15", r); end
      n_cmp++; if (va !== 65) begin n_fail++; $display("[TB] FAIL after_done_valid_at: got %0d expected 65", va); end
   endtask

   task automatic test_abort();
      int va, vc, bc, r, pulses; bit to, reached;
      load_pattern1();
      reached = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = MODE_UNION; bus.sel_mask = 4'b0011; bus.k = 3'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.rd_addr == 6'd30) begin reached = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_cmp++; if (reached !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_reach_addr30: got %b expected 1", reached); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
      n_cmp++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_rd_en: got %b expected 0", bus.rd_en); end
      n_cmp++; if (bus.rd_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL abort_rd_addr: got %0d expected 0", bus.rd_addr); end
      n_cmp++; if (bus.result !== 7'd0) begin n_fail++; $display("[TB] FAIL abort_result: got %0d expected 0", bus.result); end
      @(negedge clk); rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (bus.valid) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_fail++; $display("[TB] FAIL abort_valid_pulses: got %0d expected 0", pulses); end
      n_cmp++; if (bus.result !== 7'd0) begin n_fail++; $display("[TB] FAIL abort_result_held: got %0d expected 0", bus.result); end
      applyStimulus(MODE_UNION, 4'b0011, 3'd0, -5, 3'd0, 4'd0, 1'b0, va, vc, bc, r, to);
      n_cmp++; if (r !== 20) begin n_fail++; $display("[TB] FAIL post_abort_result: got %0d expected 20", r); end
      n_cmp++; if (va !== 65) begin n_fail++; $display("[TB] FAIL post_abort_valid_at: got %0d expected 65", va); end
`ifdef SET_SCAN_POP_EN
      n_cmp++; if (bus.set_pop[6:0] !== 7'd10) begin n_fail++; $display("[TB] FAIL pop_map0: got %0d expected 10", bus.set_pop[6:0]); end
      n_cmp++; if (bus.set_pop[13:7] !== 7'd15) begin n_fail++; $display("[TB] FAIL pop_map1: got %0d expected 15", bus.set_pop[13:7]); end
      n_cmp++; if (bus.set_pop[20:14] !== 7'd0) begin n_fail++; $display("[TB] FAIL pop_map2: got %0d expected 0", bus.set_pop[20:14]); end
      n_cmp++; if (bus.set_pop[27:21] !== 7'd64) begin n_fail++; $display("[TB] FAIL pop_map3: got %0d expected 64", bus.set_pop[27:21]); end
`endif
   endtask

   initial begin
      $display("[TB] set_scan_ctrl bench start");
      test_reset();
      test_union_inter_parity();
      test_thresholds();
      test_mask_zero_reserved();
      test_back_to_back();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/set_scan_ctrl.md
Name: set_scan_ctrl

Overview:
- Parametrised scan controller for bit-map set operations across NUM_SETS single-bit-wide map memories of DEPTH entries.
- Sweeps a shared read address across all maps and evaluates a per-address set predicate on the returned bits (union, intersection, parity, exactly-K, at-least-K over a selectable subset of maps).
- Counts matching addresses into a result register.
- Sits between the host command interface and the map cell array; successor to the fixed 3-map controller.

Parameters:
- NUM_SETS, 4, number of map memories scanned in parallel (2..8).
- DEPTH, 64, entries per map; scan covers addresses 0..DEPTH-1.
- ADDR_W, $clog2(DEPTH), read address width (derived).
- CNT_W, $clog2(DEPTH+1), result width; holds full count DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; accepted only in IDLE.
- mode  input  3  operation code, sampled on accepted start.
- sel_mask  input  NUM_SETS  maps participating, sampled on accepted start.
- k  input  $clog2(NUM_SETS+1)  threshold for EXACT_K/ATLEAST_K, sampled on accepted start.
- rd_en  output  1  read strobe to all maps.
- rd_addr  output  ADDR_W  shared read address.
- rd_bit  input  NUM_SETS  map bits, valid exactly one cycle after rd_en.
- busy  output  1  high from accepted start through DONE inclusive.
- valid  output  1  one-cycle pulse in DONE.
- result  output  CNT_W  match count; stable from DONE until next accepted start.

Behaviour:
- Reset (async): state=IDLE, rd_en=0, rd_addr=0, busy=0, valid=0, result=0, internal bit_vld=0, latched mode/mask/k=0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 at edge E0 latches mode/sel_mask/k, clears result, sets rd_addr=0, rd_en=1, and moves to FETCH.
  - start=0 stays in IDLE.
- FETCH:
  - rd_en=1; rd_addr increments by 1 each edge.
  - When rd_addr==DEPTH-1 is issued, the next edge moves to DRAIN with rd_en=0.
  - rd_addr wraps to 0 on leaving FETCH.
- DRAIN: consumes the final read bit; the next edge moves to DONE.
- DONE: valid=1, busy=1; the next edge moves to IDLE.
- Accumulation:
  - bit_vld is rd_en delayed one cycle.
  - On each edge with bit_vld=1, result += pred(rd_bit & mask).
  - Exactly DEPTH accumulations per command.
- Latency: valid high between edge E0+DEPTH+1 and E0+DEPTH+2. Total busy duration is DEPTH+2 cycles.
- Predicate on m = rd_bit & mask; p = popcount(m), n = popcount(mask):
  - 0 UNION: p!=0.
  - 1 INTER: n!=0 && p==n.
  - 2 PARITY: p odd.
  - 3 EXACT_K: p==k.
  - 4 ATLEAST_K: p>=k; k=0 matches every address.
  - 5..7 reserved: predicate false, result=0, timing unchanged.
- mask=0: UNION/INTER/PARITY yield 0; EXACT_K with k=0 yields DEPTH.
- start while busy (including DONE) is ignored, with no effect on the latched operands.
- rd_bit is ignored whenever bit_vld=0.
- rst mid-scan aborts immediately to reset values. No valid pulse is produced, and the previous result is lost (result=0).
- result never overflows, since CNT_W covers DEPTH.

Optional Feature:
- Macro: SET_SCAN_POP_EN.
- Defined:
  - Adds output set_pop (NUM_SETS*CNT_W).
  - Per-map count of 1 bits over the same scan, ignoring sel_mask.
  - Cleared on accepted start and on reset; stable with result.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package set_scan_pkg holds:
  - mode codes as localparams/enum: UNION, INTER, PARITY, EXACT_K, ATLEAST_K;
  - state encoding;
  - popcount function.
- Sub-module set_scan_pred: combinational predicate (m, mask, k, mode -> match). Reusable by future word-wide variants.

Test Plan:
- Reset: rst pulse mid-cycle -> all outputs 0 asynchronously; state IDLE.
- UNION, NUM_SETS=4, DEPTH=64, mask=4'b0011, map0 bits at addr 0..9, map1 bits at addr 5..19 -> valid at E0+65, result=20, busy high 66 cycles.
- INTER, same maps -> result=5. PARITY, same maps -> result=15.
- EXACT_K k=2, mask=4'b1111, all four maps at even addrs, map0 also at odd addrs -> result=0. ATLEAST_K k=1 on same maps -> result=64 (full count, no overflow).
- start asserted during FETCH with different mode -> ignored; result matches original mode; start in the cycle after DONE accepted.
- rst at scan address 30 -> no valid pulse, result=0; new start then completes normally. With SET_SCAN_POP_EN, set_pop per map equals preloaded bit counts (10, 15, 0, 64).
